// File: rtl/icache_pkg.sv
// Shared widths, bus command encoding and fill FSM states for the icache fill controller.
package icache_pkg;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;
  localparam int IDX_LSB   = 3;
  localparam int IDX_W     = 5;
  localparam int TAG_LSB   = 8;
  localparam int TAG_W     = 8;
  localparam int BUS_TAG_W = 4;
  localparam int STAT_W    = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fill_state_e;

endpackage

// File: rtl/icache_stat_ctr.sv
// Saturating event counter used by the optional fill statistics.
module icache_stat_ctr
  import icache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_inc,
  output logic [STAT_W-1:0] o_count
);

  logic [STAT_W-1:0] r_count;

  // Holds at all-ones rather than wrapping back to zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + STAT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/icache_fill_ctrl.sv
// Instruction cache miss/fill controller: combinational hit path, one outstanding tagged load.
// Define ICACHE_FILL_STATS_EN to add the stat_hits/stat_misses/stat_retries counters.
module icache_fill_ctrl
  import icache_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    proc2Icache_addr,
  output logic [DATA_W-1:0]    Icache_data_out,
  output logic                 Icache_valid_out,
  output logic [IDX_W-1:0]     cache_rd_idx,
  output logic [TAG_W-1:0]     cache_rd_tag,
  input  logic [DATA_W-1:0]    cache_rd_data,
  input  logic                 cache_rd_valid,
  output logic                 cache_wr_en,
  output logic [IDX_W-1:0]     cache_wr_idx,
  output logic [TAG_W-1:0]     cache_wr_tag,
  output logic [DATA_W-1:0]    cache_wr_data,
  output logic [1:0]           proc2Imem_command,
  output logic [ADDR_W-1:0]    proc2Imem_addr,
  input  logic [BUS_TAG_W-1:0] Imem2proc_response,
  input  logic [DATA_W-1:0]    Imem2proc_data,
  input  logic [BUS_TAG_W-1:0] Imem2proc_tag
`ifdef ICACHE_FILL_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_hits,
  output logic [STAT_W-1:0]    stat_misses,
  output logic [STAT_W-1:0]    stat_retries
`endif
);

  fill_state_e          r_state;
  logic [BUS_TAG_W-1:0] r_resp_tag;
  logic [IDX_W-1:0]     r_fill_idx;
  logic [TAG_W-1:0]     r_fill_tag;

  logic w_miss_req;
  logic w_accepted;
  logic w_fill_hit;
  logic w_unused_lsb;

  assign cache_rd_idx     = proc2Icache_addr[IDX_LSB +: IDX_W];
  assign cache_rd_tag     = proc2Icache_addr[TAG_LSB +: TAG_W];
  assign Icache_data_out  = cache_rd_data;
  assign Icache_valid_out = cache_rd_valid;
  assign proc2Imem_addr   = {proc2Icache_addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
  assign w_unused_lsb     = ^proc2Icache_addr[IDX_LSB-1:0];

  // Reset gates the bus request and the fill strobe so nothing leaks out while held in reset.
  assign w_miss_req = reset && (r_state == IDLE) && !cache_rd_valid;
  assign w_accepted = w_miss_req && (Imem2proc_response != '0);
  assign w_fill_hit = reset && (r_state == WAIT) && (r_resp_tag != '0)
                      && (Imem2proc_tag == r_resp_tag);

  assign proc2Imem_command = w_miss_req ? BUS_LOAD : BUS_NONE;
  assign cache_wr_en       = w_fill_hit;
  assign cache_wr_idx      = r_fill_idx;
  assign cache_wr_tag      = r_fill_tag;
  assign cache_wr_data     = Imem2proc_data;

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_resp_tag <= '0;
      r_fill_idx <= '0;
      r_fill_tag <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accepted) begin
            r_state    <= WAIT;
            r_resp_tag <= Imem2proc_response;
            r_fill_idx <= cache_rd_idx;
            r_fill_tag <= cache_rd_tag;
          end
        end
        WAIT: begin
          if (w_fill_hit) begin
            r_state    <= IDLE;
            r_resp_tag <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_FILL_STATS_EN
  logic w_retry;
  assign w_retry = w_miss_req && (Imem2proc_response == '0);

  icache_stat_ctr u_stat_hits (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (Icache_valid_out),
    .o_count (stat_hits)
  );

  icache_stat_ctr u_stat_misses (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_accepted),
    .o_count (stat_misses)
  );

  icache_stat_ctr u_stat_retries (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_retry),
    .o_count (stat_retries)
  );
`endif

endmodule
